twiddle_stream_generator: RTL and testbench

Sequential consumer of the fixed-point sine-wave table used by the FFT twiddle path. Given an FFT stage index, it walks the table and streams the SIZE_FFT/2 twiddle factors W = cos(θ) − j·sin(θ) for every butterfly of that stage, in butterfly order, over a val/rdy interface. It sits between the sine-wave table and the butterfly array / stage controller.

---
 rtl/twiddle_stream_generator.sv | 63 ++++++
 tb/tb_twiddle_stream_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_stream_generator.sv
// twiddle_stream_generator: streams the SIZE_FFT/2 twiddle factors of one FFT stage
// by indexing a one-period sine table with quarter- and half-period offsets.
module twiddle_stream_generator #(
   parameter int BIT_WIDTH     = 32,
   parameter int DECIMAL_POINT = 16,
   parameter int SIZE_FFT      = 32,
   localparam int LOG = $clog2(SIZE_FFT),
   localparam int SW  = $clog2(LOG),
   localparam int JW  = $clog2(SIZE_FFT / 2)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] sine_wave_in [0:SIZE_FFT-1],
   input  logic                 start_val,
   output logic                 start_rdy,
   input  logic [SW-1:0]        start_stage,
   output logic                 tw_val,
   input  logic                 tw_rdy,
   output logic [BIT_WIDTH-1:0] tw_real,
   output logic [BIT_WIDTH-1:0] tw_imag,
   output logic [JW-1:0]        tw_index,
   output logic                 tw_last
);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t          r_state;
   logic [JW-1:0]   r_j;
   logic [SW-1:0]   r_s;
   logic [JW-1:0]   w_mask, w_idx;
   logic [LOG-1:0]  w_re_i, w_im_i;
   logic            w_stream;
   if (DECIMAL_POINT > BIT_WIDTH) begin : g_q_format_wider_than_word
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_j     <= '0;
         r_s     <= '0;
      end else if (r_state == IDLE) begin
         if (start_val) begin
            r_s     <= ({1'b0, start_stage} >= (SW+1)'(LOG)) ? SW'(LOG - 1) : start_stage;
            r_j     <= '0;
            r_state <= STREAM;
         end
      end else if (tw_rdy) begin
         if (&r_j) r_state <= IDLE;
         else r_j <= r_j + 1'b1;
      end
   end
   // Table offsets of +N/4 and +N/2 give cos and -sin; the add wraps modulo SIZE_FFT.
   always_comb begin
      w_mask    = JW'((32'd1 << r_s) - 32'd1);
      w_idx     = (r_j & w_mask) << (LOG - 1 - int'(r_s));
      w_re_i    = {1'b0, w_idx} + LOG'(SIZE_FFT / 4);
      w_im_i    = {1'b0, w_idx} + LOG'(SIZE_FFT / 2);
      w_stream  = !reset && (r_state == STREAM);
      start_rdy = !reset && (r_state == IDLE);
      tw_val    = w_stream;
      tw_real   = w_stream ? sine_wave_in[w_re_i] : '0;
      tw_imag   = w_stream ? sine_wave_in[w_im_i] : '0;
      tw_index  = w_stream ? r_j : '0;
      tw_last   = w_stream && (&r_j);
   end
endmodule

// File: tb/tb_twiddle_stream_generator.sv
// tb_twiddle_stream_generator: scoreboard bench; the driver queues expected beats from an
// angle-based model, a negedge monitor pops and compares every accepted beat.
module tb_twiddle_stream_generator;
   localparam int N   = 32;
   localparam int N2  = N / 2;
   localparam int LOG = 5;

   typedef struct {
      logic [31:0] re, im, sre, sim;
      logic [3:0]  idx;
      bit          last, sp;
   } item_t;

   logic        clk = 0, reset = 1, start_val = 0, tw_rdy = 0;
   logic [2:0]  start_stage = '0;
   logic        start_rdy, tw_val, tw_last;
   logic [31:0] tw_real, tw_imag;
   logic [3:0]  tw_index;
   logic [31:0] tbl [0:N-1];
   item_t       q[$];
   int          checks = 0, errors = 0;
   bit          sine_mode = 1;

   twiddle_stream_generator dut (
      .clk(clk), .reset(reset), .sine_wave_in(tbl),
      .start_val(start_val), .start_rdy(start_rdy), .start_stage(start_stage),
      .tw_val(tw_val), .tw_rdy(tw_rdy), .tw_real(tw_real), .tw_imag(tw_imag),
      .tw_index(tw_index), .tw_last(tw_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0d (0x%h) expected %0d (0x%h)", nm, $signed(a), a, $signed(e), e);
      end
   endtask

   function automatic bit spot(input int s, input int j, output logic [31:0] re, output logic [31:0] im);
      re = '0;
      im = '0;
      if (s == 0) begin re = 65536; return 1; end
      if (s == 1 && j == 1) begin im = -65536; return 1; end
      if (s == 2 && (j == 1 || j == 5)) begin re = 46340; im = -46340; return 1; end
      if (s == 2 && j == 2) begin im = -65536; return 1; end
      if (s == 4 && j == 1) begin re = 64276; im = -12785; return 1; end
      if (s == 4 && j == 8) begin im = -65536; return 1; end
      if (s == 4 && j == 15) begin re = -64276; im = -12785; return 1; end
      return 0;
   endfunction

   // Butterfly j of stage s uses angle 2*pi*a/N with a = (j mod 2^s) * N/2^(s+1).
   function automatic void push_stage(input int st);
      int s;
      s = (st >= LOG) ? LOG - 1 : st;
      for (int j = 0; j < N2; j++) begin
         item_t e;
         int a;
         a = (j % (1 << s)) * (N / (1 << (s + 1)));
         e.re   = tbl[(a + N / 4) % N];
         e.im   = tbl[(a + N / 2) % N];
         e.idx  = 4'(j);
         e.last = (j == N2 - 1);
         e.sp   = spot(s, j, e.sre, e.sim) & sine_mode;
         q.push_back(e);
      end
   endfunction

   task automatic load_sine();
      real x;
      sine_mode = 1;
      for (int i = 0; i < N; i++) begin
         x = $sin(2.0 * 3.14159265358979 * i / 32.0);
         tbl[i] = $rtoi(x * 65536.0 + ((x < 0.0) ? -1.0e-6 : 1.0e-6));
      end
   endtask

   task automatic load_random();
      sine_mode = 0;
      for (int i = 0; i < N; i++) tbl[i] = $urandom;
   endtask

   task automatic start_req(input int st);
      int n;
      n = 0;
      @(posedge clk); #1;
      start_val   = 1;
      start_stage = 3'(st);
      push_stage(st);
      do begin
         @(negedge clk);
         n++;
      end while (!start_rdy && n < 50);
      @(posedge clk); #1;
      start_val = 0;
      if (n >= 50) begin
         errors++;
         $display("FAIL start_timeout start_rdy never rose");
      end
      @(negedge clk);
      chk("first_beat_latency", tw_val, 1);
   endtask

   task automatic drain(input int pct, input bit pulse, input int nxt);
      int n;
      n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(posedge clk); #1;
         tw_rdy = ($urandom_range(99) < pct);
         if (nxt >= 0 && q.size() <= 1) begin
            start_val   = 1;
            start_stage = 3'(nxt);
         end else if (pulse && q.size() >= 2) begin
            start_val   = 1'($urandom_range(1));
            start_stage = 3'($urandom_range(7));
         end else start_val = 0;
         n++;
      end
      if (n >= 2000) begin
         errors++;
         $display("FAIL drain_timeout %0d beats left", q.size());
         q.delete();
      end
      if (nxt >= 0) begin
         push_stage(nxt);
         @(posedge clk); #1;
         start_val = 0;
         @(negedge clk);
         chk("b2b_first_beat", tw_val, 1);
      end
      start_val = 0;
   endtask

   bit          held_v = 0, after_last = 0;
   logic [31:0] h_re, h_im;
   logic [3:0]  h_idx;
   logic        h_last;
   always @(negedge clk) begin
      item_t e;
      if (reset) begin
         chk("rst_tw_val", tw_val, 0);
         chk("rst_start_rdy", start_rdy, 0);
         chk("rst_tw_last", tw_last, 0);
         chk("rst_tw_real", tw_real, 0);
         held_v     = 0;
         after_last = 0;
      end else begin
         if (after_last) begin
            chk("post_last_start_rdy", start_rdy, 1);
            chk("post_last_tw_val", tw_val, 0);
            chk("post_last_tw_index", 32'(tw_index), 0);
         end
         after_last = 0;
         if (held_v) begin
            chk("stall_val", tw_val, 1);
            chk("stall_real", tw_real, h_re);
            chk("stall_imag", tw_imag, h_im);
            chk("stall_index", 32'(tw_index), 32'(h_idx));
            chk("stall_last", tw_last, h_last);
         end
         if (tw_val) chk("stream_start_rdy", start_rdy, 0);
         if (tw_val && tw_rdy) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat index %0d with empty scoreboard", tw_index);
            end else begin
               e = q.pop_front();
               chk("tw_real", tw_real, e.re);
               chk("tw_imag", tw_imag, e.im);
               chk("tw_index", 32'(tw_index), 32'(e.idx));
               chk("tw_last", tw_last, e.last);
               if (e.sp) begin
                  chk("const_real", tw_real, e.sre);
                  chk("const_imag", tw_imag, e.sim);
               end
               after_last = e.last;
            end
         end
         held_v = tw_val && !tw_rdy;
         h_re   = tw_real;
         h_im   = tw_imag;
         h_idx  = tw_index;
         h_last = tw_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nx;
      load_sine();
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("after_reset_start_rdy", start_rdy, 1);
      chk("after_reset_tw_val", tw_val, 0);
      tw_rdy = 1;
      start_req(0); drain(100, 0, -1);
      start_req(4); drain(100, 1, -1);
      start_req(2); drain(50, 0, -1);
      start_req(7); drain(70, 1, -1);
      start_req(4); drain(100, 0, 0); drain(100, 0, -1);
      tw_rdy = 1;
      start_req(3);
      n = 0;
      while (tw_index != 4'd5 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reach_beat5", 32'(tw_index), 5);
      @(posedge clk); #1;
      reset = 1;
      q.delete();
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("abort_tw_val", tw_val, 0);
      chk("abort_start_rdy", start_rdy, 1);
      start_req(1); drain(60, 0, -1);
      for (int i = 0; i < 24; i++) begin
         if (i % 6 == 0) begin
            @(posedge clk); #1;
            load_random();
         end
         nx = (i % 5 == 4) ? int'($urandom_range(7)) : -1;
         start_req($urandom_range(7));
         drain($urandom_range(30, 100), 1'($urandom_range(1)), nx);
         if (nx >= 0) drain($urandom_range(30, 100), 0, -1);
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
